// File: rtl/rack_spike_tx.sv
// ============================================================================
// Module   : rack_spike_tx
// Purpose  : Rack spike-link transmitter that turns spike strobes into pulses
//            of fixed width and gap, and drives a held remote-reset line.
// Option   : RACK_SPIKE_TX_DROP_CNT_EN enables the 16-bit dropped counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rack_spike_tx #(
   parameter int HIGH_CYCLES = 4,
   parameter int LOW_CYCLES  = 4,
   parameter int PEND_W      = 4,
   parameter int RST_HOLD    = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              spike_in,
   input  logic              sim_tick,
   input  logic              remote_reset_req,
   output logic              spike_out,
   output logic              remote_reset_out,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic [15:0]       dropped
);

   localparam int c_tmr_max = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
   localparam int c_tmr_w   = (c_tmr_max > 1) ? $clog2(c_tmr_max) : 1;
   localparam int c_hold_w  = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;

   localparam logic [c_tmr_w-1:0]  c_high_load = c_tmr_w'(HIGH_CYCLES - 1);
   localparam logic [c_tmr_w-1:0]  c_low_load  = c_tmr_w'(LOW_CYCLES - 1);
   localparam logic [c_tmr_w-1:0]  c_tmr_one   = c_tmr_w'(1);
   localparam logic [c_hold_w-1:0] c_hold_load = c_hold_w'(RST_HOLD);
   localparam logic [c_hold_w-1:0] c_hold_one  = c_hold_w'(1);
   localparam logic [PEND_W-1:0]   c_pend_max  = '1;
   localparam logic [PEND_W-1:0]   c_pend_one  = PEND_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [c_tmr_w-1:0]  tmr_q, tmr_d;
   logic [PEND_W-1:0]   pend_q, pend_d;
   logic                spike_q, spike_d;
   logic                rr_q, rr_d;
   logic [c_hold_w-1:0] hold_q, hold_d;

   logic w_kill;
   logic w_want;
   logic w_launch;
   logic w_from_q;
   logic w_accept;
   logic w_inc;
   logic w_full;

   // The remote-reset request itself already silences the link so that
   // spike_out is low on the first cycle remote_reset_out is high.
   assign w_kill = remote_reset_req | rr_q;
   assign w_want = spike_in | (pend_q != '0);

   always_comb begin
      state_d  = state_q;
      tmr_d    = tmr_q;
      w_launch = 1'b0;
      if (w_kill) begin
         state_d = ST_IDLE;
         tmr_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (w_want) begin
                  state_d  = ST_HIGH;
                  tmr_d    = c_high_load;
                  w_launch = 1'b1;
               end
            end
            ST_HIGH: begin
               if (tmr_q == '0) begin
                  state_d = ST_LOW;
                  tmr_d   = c_low_load;
               end else begin
                  tmr_d = tmr_q - c_tmr_one;
               end
            end
            ST_LOW: begin
               if (tmr_q == '0) begin
                  if (w_want) begin
                     state_d  = ST_HIGH;
                     tmr_d    = c_high_load;
                     w_launch = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  tmr_d = tmr_q - c_tmr_one;
               end
            end
            default: begin
               state_d = ST_IDLE;
               tmr_d   = '0;
            end
         endcase
      end
      spike_d = (state_d == ST_HIGH);
   end

   // A launch drains the queue first; only with an empty queue does it take
   // the same-cycle spike directly.
   assign w_from_q = w_launch & (pend_q != '0);
   assign w_accept = spike_in & ~w_kill & ~(w_launch & (pend_q == '0));
   assign w_inc    = w_accept & ~w_from_q;
   assign w_full   = (pend_q == c_pend_max);

   always_comb begin
      pend_d = pend_q;
      if (w_kill) begin
         pend_d = '0;
      end else if (w_inc) begin
         if (!w_full) begin
            pend_d = pend_q + c_pend_one;
         end
      end else if (w_from_q && !w_accept) begin
         pend_d = pend_q - c_pend_one;
      end
   end

   always_comb begin
      rr_d   = rr_q;
      hold_d = hold_q;
      if (remote_reset_req) begin
         rr_d   = 1'b1;
         hold_d = c_hold_load;
      end else if (rr_q && sim_tick) begin
         if (hold_q <= c_hold_one) begin
            rr_d   = 1'b0;
            hold_d = '0;
         end else begin
            hold_d = hold_q - c_hold_one;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         tmr_q   <= '0;
         pend_q  <= '0;
         spike_q <= 1'b0;
         rr_q    <= 1'b0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         pend_q  <= pend_d;
         spike_q <= spike_d;
         rr_q    <= rr_d;
         hold_q  <= hold_d;
      end
   end

`ifdef RACK_SPIKE_TX_DROP_CNT_EN
   logic [15:0] drop_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         drop_q <= '0;
      end else if (w_inc && w_full && (drop_q != 16'hFFFF)) begin
         drop_q <= drop_q + 16'd1;
      end
   end

   assign dropped = drop_q;
`else
   assign dropped = 16'd0;
`endif

   assign spike_out        = spike_q;
   assign remote_reset_out = rr_q;
   assign pending          = pend_q;
   assign busy             = (state_q != ST_IDLE) | (pend_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_rack_spike_tx.sv
// ============================================================================
// Module   : tb_rack_spike_tx
// Purpose  : Self-checking bench for rack_spike_tx (default build and with
//            RACK_SPIKE_TX_DROP_CNT_EN defined).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rack_spike_tx;

`ifdef RACK_SPIKE_TX_DROP_CNT_EN
   localparam bit c_drop_en = 1'b1;
`else
   localparam bit c_drop_en = 1'b0;
`endif
   localparam logic [15:0] c_drop_ovf = c_drop_en ? 16'd4 : 16'd0;

   logic        clk = 1'b0;
   logic        reset, spike_in, spike_in2, sim_tick, remote_reset_req;
   logic        spike_out, remote_reset_out, busy;
   logic        spike_out2, remote_reset_out2, busy2;
   logic [3:0]  pending;
   logic [1:0]  pending2;
   logic [15:0] dropped, dropped2;

   int tests = 0;
   int fails = 0;
   int rise_q[$];

   always #5 clk = ~clk;

   rack_spike_tx #(.HIGH_CYCLES(4), .LOW_CYCLES(4), .PEND_W(4), .RST_HOLD(2)) u_dut (
      .clk(clk), .reset(reset), .spike_in(spike_in), .sim_tick(sim_tick),
      .remote_reset_req(remote_reset_req), .spike_out(spike_out),
      .remote_reset_out(remote_reset_out), .busy(busy), .pending(pending),
      .dropped(dropped)
   );

   rack_spike_tx #(.HIGH_CYCLES(4), .LOW_CYCLES(4), .PEND_W(2), .RST_HOLD(2)) u_dut2 (
      .clk(clk), .reset(reset), .spike_in(spike_in2), .sim_tick(sim_tick),
      .remote_reset_req(remote_reset_req), .spike_out(spike_out2),
      .remote_reset_out(remote_reset_out2), .busy(busy2), .pending(pending2),
      .dropped(dropped2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tests += 10;
      if (spike_out !== 1'b0)        begin fails++; $display("FAIL reset_spike_out: got %b expected 0", spike_out); end
      if (remote_reset_out !== 1'b0) begin fails++; $display("FAIL reset_rr: got %b expected 0", remote_reset_out); end
      if (busy !== 1'b0)             begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
      if (pending !== 4'd0)          begin fails++; $display("FAIL reset_pending: got %0d expected 0", pending); end
      if (dropped !== 16'd0)         begin fails++; $display("FAIL reset_dropped: got %0d expected 0", dropped); end
      if (spike_out2 !== 1'b0)       begin fails++; $display("FAIL reset_spike_out2: got %b expected 0", spike_out2); end
      if (remote_reset_out2 !== 1'b0) begin fails++; $display("FAIL reset_rr2: got %b expected 0", remote_reset_out2); end
      if (busy2 !== 1'b0)            begin fails++; $display("FAIL reset_busy2: got %b expected 0", busy2); end
      if (pending2 !== 2'd0)         begin fails++; $display("FAIL reset_pending2: got %0d expected 0", pending2); end
      if (dropped2 !== 16'd0)        begin fails++; $display("FAIL reset_dropped2: got %0d expected 0", dropped2); end
   endtask

   task automatic test_single();
      bit prev = 1'b0;
      int hi_len = 0;
      int exp_r;
      bit exp_busy;
      rise_q.delete();
      rise_q.push_back(1);
      for (int i = 0; i < 14; i++) begin
         int c;
         spike_in = (i == 0);
         step();
         c = i + 1;
         if (spike_out && !prev) begin
            tests++;
            if (rise_q.size() == 0) begin
               fails++; $display("FAIL single_rise: unexpected rise at cycle %0d", c);
            end else begin
               exp_r = rise_q.pop_front();
               if (c !== exp_r) begin fails++; $display("FAIL single_rise: got cycle %0d expected %0d", c, exp_r); end
            end
            hi_len = 0;
         end
         if (spike_out) hi_len++;
         if (!spike_out && prev) begin
            tests++;
            if (hi_len !== 4) begin fails++; $display("FAIL single_width: got %0d expected 4", hi_len); end
         end
         prev = spike_out;
         exp_busy = (c >= 1) && (c <= 8);
         tests += 2;
         if (busy !== exp_busy) begin fails++; $display("FAIL single_busy: got %b expected %b at cycle %0d", busy, exp_busy, c); end
         if (pending !== 4'd0)  begin fails++; $display("FAIL single_pending: got %0d expected 0 at cycle %0d", pending, c); end
      end
      tests++;
      if (rise_q.size() != 0) begin fails++; $display("FAIL single_missing_rise: got %0d left expected 0", rise_q.size()); end
   endtask

   task automatic test_burst();
      bit prev = 1'b0;
      int hi_len = 0;
      int exp_r;
      int exp_p;
      int peak = 0;
      rise_q.delete();
      rise_q.push_back(1);
      rise_q.push_back(9);
      rise_q.push_back(17);
      for (int i = 0; i < 30; i++) begin
         int c;
         spike_in = (i <= 2);
         step();
         c = i + 1;
         if (spike_out && !prev) begin
            tests++;
            if (rise_q.size() == 0) begin
               fails++; $display("FAIL burst_rise: unexpected rise at cycle %0d", c);
            end else begin
               exp_r = rise_q.pop_front();
               if (c !== exp_r) begin fails++; $display("FAIL burst_rise: got cycle %0d expected %0d", c, exp_r); end
            end
            hi_len = 0;
         end
         if (spike_out) hi_len++;
         if (!spike_out && prev) begin
            tests++;
            if (hi_len !== 4) begin fails++; $display("FAIL burst_width: got %0d expected 4", hi_len); end
         end
         prev = spike_out;
         if (c < 2)       exp_p = 0;
         else if (c == 2) exp_p = 1;
         else if (c < 9)  exp_p = 2;
         else if (c < 17) exp_p = 1;
         else             exp_p = 0;
         if (int'(pending) > peak) peak = int'(pending);
         tests++;
         if (int'(pending) !== exp_p) begin fails++; $display("FAIL burst_pending: got %0d expected %0d at cycle %0d", pending, exp_p, c); end
      end
      tests += 2;
      if (peak !== 2) begin fails++; $display("FAIL burst_peak: got %0d expected 2", peak); end
      if (rise_q.size() != 0) begin fails++; $display("FAIL burst_missing_rise: got %0d left expected 0", rise_q.size()); end
   endtask

   task automatic test_overflow();
      int exp_p;
      for (int i = 0; i < 8; i++) begin
         int c;
         spike_in2 = 1'b1;
         step();
         c = i + 1;
         if (c < 2)       exp_p = 0;
         else if (c == 2) exp_p = 1;
         else if (c == 3) exp_p = 2;
         else             exp_p = 3;
         tests++;
         if (int'(pending2) !== exp_p) begin fails++; $display("FAIL ovf_pending: got %0d expected %0d at cycle %0d", pending2, exp_p, c); end
      end
      spike_in2 = 1'b0;
      tests += 2;
      if (dropped2 !== c_drop_ovf) begin fails++; $display("FAIL ovf_dropped: got %0d expected %0d", dropped2, c_drop_ovf); end
      if (dropped !== 16'd0)       begin fails++; $display("FAIL ovf_dropped_main: got %0d expected 0", dropped); end
   endtask

   task automatic test_abort();
      bit prev = 1'b0;
      int exp_r;
      int exp_p;
      bit exp_rr;
      rise_q.delete();
      rise_q.push_back(1);
      rise_q.push_back(10);
      for (int i = 0; i < 22; i++) begin
         int c;
         spike_in         = (i < 3) || (i >= 4 && i <= 9);
         spike_in2        = (i >= 4 && i <= 8);
         remote_reset_req = (i == 3);
         sim_tick         = (i == 6) || (i == 8);
         step();
         c = i + 1;
         if (spike_out && !prev) begin
            tests++;
            if (rise_q.size() == 0) begin
               fails++; $display("FAIL abort_rise: unexpected rise at cycle %0d", c);
            end else begin
               exp_r = rise_q.pop_front();
               if (c !== exp_r) begin fails++; $display("FAIL abort_rise: got cycle %0d expected %0d", c, exp_r); end
            end
         end
         prev = spike_out;
         exp_rr = (c >= 4) && (c <= 8);
         if (c == 2)      exp_p = 1;
         else if (c == 3) exp_p = 2;
         else             exp_p = 0;
         tests += 2;
         if (remote_reset_out !== exp_rr) begin fails++; $display("FAIL abort_rr: got %b expected %b at cycle %0d", remote_reset_out, exp_rr, c); end
         if (int'(pending) !== exp_p) begin fails++; $display("FAIL abort_pending: got %0d expected %0d at cycle %0d", pending, exp_p, c); end
         if (c == 4) begin
            tests++;
            if (spike_out !== 1'b0) begin fails++; $display("FAIL abort_truncate: got %b expected 0", spike_out); end
         end
         if (c >= 4) begin
            tests += 3;
            if (pending2 !== 2'd0) begin fails++; $display("FAIL abort_pending2: got %0d expected 0 at cycle %0d", pending2, c); end
            if (dropped2 !== c_drop_ovf) begin fails++; $display("FAIL abort_dropped2: got %0d expected %0d at cycle %0d", dropped2, c_drop_ovf, c); end
            if (spike_out2 !== 1'b0) begin fails++; $display("FAIL abort_spike_out2: got %b expected 0 at cycle %0d", spike_out2, c); end
         end
      end
      spike_in = 1'b0;
      tests++;
      if (rise_q.size() != 0) begin fails++; $display("FAIL abort_missing_rise: got %0d left expected 0", rise_q.size()); end
   endtask

   task automatic test_remote_reset();
      logic [63:0] req_m;
      logic [63:0] tick_m;
      int          fall;
      bit          exp_rr;
      for (int s = 0; s < 3; s++) begin
         case (s)
            0: begin req_m = 64'h1;                 tick_m = (64'h1 << 10) | (64'h1 << 20);                 fall = 21; end
            1: begin req_m = 64'h1 | (64'h1 << 15); tick_m = (64'h1 << 10) | (64'h1 << 20) | (64'h1 << 30); fall = 31; end
            default: begin req_m = 64'h1 | (64'h1 << 5); tick_m = (64'h1 << 5) | (64'h1 << 10) | (64'h1 << 15); fall = 16; end
         endcase
         for (int i = 0; i < 36; i++) begin
            int c;
            remote_reset_req = req_m[i];
            sim_tick         = tick_m[i];
            step();
            c = i + 1;
            exp_rr = (c < fall);
            tests++;
            if (remote_reset_out !== exp_rr) begin
               fails++;
               $display("FAIL rr_scn%0d: got %b expected %b at cycle %0d", s, remote_reset_out, exp_rr, c);
            end
         end
      end
      remote_reset_req = 1'b0;
      sim_tick         = 1'b0;
   endtask

   task automatic test_local_reset();
      for (int i = 0; i < 4; i++) begin
         spike_in  = 1'b1;
         spike_in2 = 1'b1;
         step();
      end
      tests += 4;
      if (pending !== 4'd3)        begin fails++; $display("FAIL lrst_pre_pending: got %0d expected 3", pending); end
      if (pending2 !== 2'd3)       begin fails++; $display("FAIL lrst_pre_pending2: got %0d expected 3", pending2); end
      if (spike_out !== 1'b1)      begin fails++; $display("FAIL lrst_pre_spike_out: got %b expected 1", spike_out); end
      if (dropped2 !== c_drop_ovf) begin fails++; $display("FAIL lrst_pre_dropped2: got %0d expected %0d", dropped2, c_drop_ovf); end
      reset = 1'b1;
      step();
      tests += 8;
      if (spike_out !== 1'b0)  begin fails++; $display("FAIL lrst_spike_out: got %b expected 0", spike_out); end
      if (busy !== 1'b0)       begin fails++; $display("FAIL lrst_busy: got %b expected 0", busy); end
      if (pending !== 4'd0)    begin fails++; $display("FAIL lrst_pending: got %0d expected 0", pending); end
      if (spike_out2 !== 1'b0) begin fails++; $display("FAIL lrst_spike_out2: got %b expected 0", spike_out2); end
      if (busy2 !== 1'b0)      begin fails++; $display("FAIL lrst_busy2: got %b expected 0", busy2); end
      if (pending2 !== 2'd0)   begin fails++; $display("FAIL lrst_pending2: got %0d expected 0", pending2); end
      if (dropped2 !== 16'd0)  begin fails++; $display("FAIL lrst_dropped2: got %0d expected 0", dropped2); end
      if (remote_reset_out !== 1'b0) begin fails++; $display("FAIL lrst_rr: got %b expected 0", remote_reset_out); end
      reset     = 1'b0;
      spike_in  = 1'b0;
      spike_in2 = 1'b0;
      step();
   endtask

   initial begin
      reset            = 1'b1;
      spike_in         = 1'b0;
      spike_in2        = 1'b0;
      sim_tick         = 1'b0;
      remote_reset_req = 1'b0;
      step();
      step();
      test_reset();
      reset = 1'b0;
      step();
      test_single();
      test_burst();
      test_overflow();
      test_abort();
      test_remote_reset();
      test_local_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rack_spike_tx.md
Name: rack_spike_tx

Overview:
- Transmit end of the rack FPGA-to-FPGA spike link.
- Takes raw one-cycle spikes from a local population, for example `each_spike`, and drives one rack spike line with pulses of guaranteed width and gap. The remote board's slower sampling clock and its async spike counter can then count every spike.
- Queues spikes that arrive while a pulse is in flight.
- Also drives the remote-reset rack line, held for a programmable number of simulation ticks so the remote board's `sim_clk` sampler sees it.

Parameters:
- HIGH_CYCLES, 4: spike_out high time in clk cycles; must be ≥1.
- LOW_CYCLES, 4: minimum spike_out low time between pulses in clk cycles; must be ≥1.
- PEND_W, 4: width of the pending-spike counter; saturates at 2^PEND_W-1.
- RST_HOLD, 2: number of sim_tick strobes that remote_reset_out stays high after the last request.

Ports:
- clk, input, 1: neuron-rate clock.
- reset, input, 1: synchronous, active-high; clears all state.
- spike_in, input, 1: one-cycle spike strobe.
- sim_tick, input, 1: one-cycle strobe per 1 ms simulation step, in the clk domain.
- remote_reset_req, input, 1: one-cycle request to reset the remote board.
- spike_out, output, 1: registered rack spike line.
- remote_reset_out, output, 1: registered rack reset line.
- busy, output, 1: high when the FSM is not IDLE or pending≠0.
- pending, output, PEND_W: number of queued spikes not yet launched.
- dropped, output, 16: saturating count of spikes lost to queue overflow.

Behaviour:
- Single clock, clk. reset is synchronous and active-high.
- Reset values: spike_out=0, remote_reset_out=0, busy=0, pending=0, dropped=0, FSM=IDLE, all counters 0.
- FSM states: IDLE, HIGH, LOW.
  - IDLE → HIGH when (spike_in | pending≠0). spike_out=1 from the next cycle. Load tmr=HIGH_CYCLES-1.
  - HIGH: spike_out=1. When tmr=0, go to LOW and load tmr=LOW_CYCLES-1. Otherwise decrement tmr.
  - LOW: spike_out=0. When tmr=0, go to HIGH if (pending≠0 | spike_in), else to IDLE. Otherwise decrement tmr.
  - Back-to-back pulse period is exactly HIGH_CYCLES+LOW_CYCLES.
- Latency: spike_in at cycle t while IDLE with pending=0 gives spike_out rising at t+1. That spike is launched directly and never enters the queue.
- Launch event: a transition into HIGH.
  - Consumes one pending spike if pending≠0; otherwise it consumes the same-cycle spike_in.
- Pending update each cycle: pending_next = pending + (spike_in accepted) − (launch consumed from queue).
  - A spike_in on a cycle with no launch adds 1.
  - A simultaneous launch-from-queue and spike_in leaves pending unchanged.
  - A spike_in consumed directly by a launch leaves pending at 0.
- Saturation: if pending=2^PEND_W-1 and a spike_in would increment it, pending holds and dropped increments.
  - dropped saturates at 16'hFFFF with no wrap.
- Remote reset:
  - remote_reset_req sets remote_reset_out=1 on the next cycle and loads hold=RST_HOLD.
  - Each sim_tick while high decrements hold. When hold would reach 0, remote_reset_out falls on the following cycle.
  - A req arriving while remote_reset_out is already high reloads hold to RST_HOLD; this is a retrigger.
  - If req and sim_tick arrive in the same cycle, req wins and hold reloads.
- Reset mid-operation, local or remote:
  - Local reset aborts any pulse immediately; spike_out=0 on the next cycle.
  - While remote_reset_out=1: the FSM is forced to IDLE, spike_out=0, spike_in is ignored (not queued, not counted as dropped), and pending is cleared to 0. Any pulse in flight is truncated.
  - Normal operation resumes on the first cycle remote_reset_out=0.
- busy = (FSM≠IDLE) | (pending≠0).

Optional Feature:
- Macro RACK_SPIKE_TX_DROP_CNT_EN.
- Defined: the 16-bit dropped counter is implemented as described in Behaviour.
- Undefined: dropped is tied to 16'd0 and no counter logic is synthesized. Overflowing spikes are still discarded silently and pending behaviour is identical.

Test Plan:
- Single spike: with HIGH=4, LOW=4, pulse spike_in at cycle 10 → spike_out high for cycles 11–14, low from 15; busy falls at cycle 19; pending stays 0 throughout.
- Burst: spike_in on 3 consecutive cycles 10,11,12 → pending peaks at 2; spike_out rises at 11, 19 and 27, each pulse 4 cycles wide; pending=0 after cycle 27.
- Overflow: with PEND_W=2, spike_in held high 8 cycles from idle → 1 launched, pending saturates at 3, dropped=4. With the macro undefined → dropped=0 and pending still 3.
- Remote reset: req at cycle 20, sim_tick at 30 and 40 with RST_HOLD=2 → remote_reset_out high from 21, low at 41. A second req at 35 → stays high until the second sim_tick after 35.
- Abort: req during the HIGH phase with pending=2 → spike_out=0 next cycle, pending=0, spike_in during the hold is ignored, dropped unchanged.
- Local reset: assert reset mid-pulse with pending=3, dropped=5 → next cycle all outputs 0.
